// File: rtl/raster_sweep_counter_pkg.sv
// Shared defaults and the controller state encoding for the raster sweep counter.
package raster_pkg;

  localparam int X_BITS_DEF = 9;
  localparam int Y_BITS_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/raster_sweep_counter_wrap.sv
// Single-axis counter: counts 0..limit-1 on inc and wraps, with clr taking priority.
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // next count: clear, wrap at limit-1, or step by one
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = {WIDTH{1'b0}};
    end else if (inc) begin
      if (at_max) begin
        value_d = {WIDTH{1'b0}};
      end else begin
        value_d = value_q + WIDTH'(1);
      end
    end else begin
      value_d = value_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      value_q <= {WIDTH{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign at_max = (value_q == (limit - WIDTH'(1)));
  assign value  = value_q;

endmodule

// File: rtl/raster_sweep_counter.sv
// Raster sweep generator: walks (x,y) row-major over a latched frame size with a
// running linear address, supporting hold, abort and continuous restart.
module raster_sweep_counter
  import raster_pkg::*;
#(
  parameter int X_BITS = X_BITS_DEF,
  parameter int Y_BITS = Y_BITS_DEF,
  localparam int ADDR_BITS = X_BITS + Y_BITS
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hold,
  input  logic                 continuous,
  input  logic [X_BITS-1:0]    x_limit,
  input  logic [Y_BITS-1:0]    y_limit,
  output logic                 busy,
  output logic                 valid,
  output logic [X_BITS-1:0]    x,
  output logic [Y_BITS-1:0]    y,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last,
  output logic                 done,
  output logic                 err
);

  state_e                state_q;
  logic [X_BITS-1:0]     xlim_q;
  logic [Y_BITS-1:0]     ylim_q;
  logic                  cont_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  done_q;
  logic                  err_q;

  logic consume_s;
  logic frame_end_s;
  logic limits_ok_s;
  logic cnt_clr_s;
  logic x_inc_s;
  logic y_inc_s;
  logic x_at_max_s;
  logic y_at_max_s;

  // counter control derived from the registered state
  always_comb begin
    consume_s   = (state_q == RUN) && !hold;
    frame_end_s = consume_s && last;
    limits_ok_s = (x_limit != {X_BITS{1'b0}}) && (y_limit != {Y_BITS{1'b0}});
    cnt_clr_s   = abort || (state_q != RUN) || frame_end_s;
    x_inc_s     = consume_s;
    y_inc_s     = consume_s && x_at_max_s;
  end

  wrap_counter #(.WIDTH(X_BITS)) u_x_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr_s),
    .inc    (x_inc_s),
    .limit  (xlim_q),
    .value  (x),
    .at_max (x_at_max_s)
  );

  // y only advances when x wraps, so it stays row-aligned
  wrap_counter #(.WIDTH(Y_BITS)) u_y_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr_s),
    .inc    (y_inc_s),
    .limit  (ylim_q),
    .value  (y),
    .at_max (y_at_max_s)
  );

  // sweep controller: state, latched frame parameters, address and pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      xlim_q  <= {X_BITS{1'b0}};
      ylim_q  <= {Y_BITS{1'b0}};
      cont_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= {ADDR_BITS{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        xlim_q  <= {X_BITS{1'b0}};
        ylim_q  <= {Y_BITS{1'b0}};
        cont_q  <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        addr_q  <= {ADDR_BITS{1'b0}};
      end else begin
        case (state_q)
          IDLE: begin
            if (start && limits_ok_s) begin
              state_q <= RUN;
              xlim_q  <= x_limit;
              ylim_q  <= y_limit;
              cont_q  <= continuous;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              addr_q  <= {ADDR_BITS{1'b0}};
            end else if (start) begin
              err_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          RUN: begin
            if (frame_end_s) begin
              done_q <= 1'b1;
              addr_q <= {ADDR_BITS{1'b0}};
              // continuous restart picks up whatever limits/mode are presented now
              if (cont_q && limits_ok_s) begin
                xlim_q <= x_limit;
                ylim_q <= y_limit;
                cont_q <= continuous;
              end else begin
                err_q   <= cont_q;
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else if (consume_s) begin
              addr_q <= addr_q + ADDR_BITS'(1);
            end else begin
              addr_q <= addr_q;
            end
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= {ADDR_BITS{1'b0}};
          end
        endcase
      end
    end
  end

  assign last  = valid_q && x_at_max_s && y_at_max_s;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign addr  = addr_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_raster_sweep_counter.sv
// Directed bench for raster_sweep_counter with hand-computed coordinate sequences.
module tb_raster_sweep_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        hold;
  logic        continuous;
  logic [8:0]  x_limit;
  logic [7:0]  y_limit;
  logic        busy;
  logic        valid;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [16:0] addr;
  logic        last;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  int ex1 [6] = '{0, 1, 2, 0, 1, 2};
  int ey1 [6] = '{0, 0, 0, 1, 1, 1};

  raster_sweep_counter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .hold       (hold),
    .continuous (continuous),
    .x_limit    (x_limit),
    .y_limit    (y_limit),
    .busy       (busy),
    .valid      (valid),
    .x          (x),
    .y          (y),
    .addr       (addr),
    .last       (last),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_coord(input string tag, input int ev, input int ex, input int ey,
                              input int ea, input int el);
    check_val({tag, ".valid"}, 32'(valid), 32'(ev));
    check_val({tag, ".x"},     32'(x),     32'(ex));
    check_val({tag, ".y"},     32'(y),     32'(ey));
    check_val({tag, ".addr"},  32'(addr),  32'(ea));
    check_val({tag, ".last"},  32'(last),  32'(el));
  endtask

  task automatic expect_idle(input string tag);
    expect_coord(tag, 0, 0, 0, 0, 0);
    check_val({tag, ".busy"}, 32'(busy), 32'd0);
    check_val({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic kick(input int xl, input int yl, input logic cont);
    x_limit    = 9'(xl);
    y_limit    = 8'(yl);
    continuous = cont;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    int t;
    int done_at;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    continuous = 1'b0; x_limit = 9'd0; y_limit = 8'd0;
    tick(); tick();
    expect_idle("reset");
    check_val("reset.err", 32'(err), 32'd0);
    resetn = 1'b1;
    tick();

    // one-shot 3x2
    kick(3, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      expect_coord($sformatf("f3x2[%0d]", i), 1, ex1[i], ey1[i], i, (i == 5) ? 1 : 0);
      check_val("f3x2.busy", 32'(busy), 32'd1);
      tick();
    end
    check_val("f3x2.done", 32'(done), 32'd1);
    check_val("f3x2.busy_end", 32'(busy), 32'd0);
    expect_coord("f3x2.end", 0, 0, 0, 0, 0);
    tick();
    check_val("f3x2.done_pulse", 32'(done), 32'd0);

    // 4x1 with hold at coordinate 2 for three cycles
    kick(4, 1, 1'b0);
    tick(); tick();
    expect_coord("hold.pre", 1, 2, 0, 2, 0);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_coord($sformatf("hold.frz[%0d]", k), 1, 2, 0, 2, 0);
    end
    hold = 1'b0;
    tick();
    expect_coord("hold.post", 1, 3, 0, 3, 1);
    t = 6;
    done_at = -1;
    for (int k = 0; k < 20 && done_at < 0; k++) begin
      tick();
      t++;
      if (done) done_at = t;
    end
    check_val("hold.done_cycle", 32'(done_at), 32'd7);

    // continuous 2x2, inputs switched to 3x1 one-shot mid-frame
    tick();
    kick(2, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_coord($sformatf("cont.f1[%0d]", i), 1, i % 2, i / 2, i, (i == 3) ? 1 : 0);
      if (i == 1) begin
        x_limit = 9'd3; y_limit = 8'd1; continuous = 1'b0;
      end
      tick();
    end
    check_val("cont.done1", 32'(done), 32'd1);
    check_val("cont.err1", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      expect_coord($sformatf("cont.f2[%0d]", i), 1, i, 0, i, (i == 2) ? 1 : 0);
      tick();
    end
    check_val("cont.done2", 32'(done), 32'd1);
    check_val("cont.busy2", 32'(busy), 32'd0);
    tick();

    // rejected start, then 1x1 frame
    kick(0, 3, 1'b0);
    check_val("rej.err", 32'(err), 32'd1);
    check_val("rej.busy", 32'(busy), 32'd0);
    check_val("rej.valid", 32'(valid), 32'd0);
    tick();
    check_val("rej.err_pulse", 32'(err), 32'd0);
    kick(1, 1, 1'b0);
    expect_coord("one", 1, 0, 0, 0, 1);
    tick();
    check_val("one.done", 32'(done), 32'd1);
    check_val("one.valid", 32'(valid), 32'd0);
    tick();

    // abort at addr 5 of 4x4
    kick(4, 4, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    expect_coord("abort.pre", 1, 1, 1, 5, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_idle("abort");
    tick();
    check_val("abort.nodone", 32'(done), 32'd0);

    // reset at addr 7 of 4x4
    kick(4, 4, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    expect_coord("rst.pre", 1, 3, 1, 7, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    expect_idle("rst");
    tick();
    check_val("rst.nodone", 32'(done), 32'd0);
    kick(4, 4, 1'b0);
    expect_coord("rst.restart", 1, 0, 0, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // start+abort in IDLE
    start = 1'b1; abort = 1'b1; x_limit = 9'd2; y_limit = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    expect_idle("stab");
    check_val("stab.err", 32'(err), 32'd0);

    // start during RUN is ignored
    kick(2, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_coord($sformatf("srun[%0d]", i), 1, i % 2, i / 2, i, (i == 3) ? 1 : 0);
      if (i == 1) begin
        start = 1'b1; x_limit = 9'd5; y_limit = 8'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check_val("srun.done", 32'(done), 32'd1);
    check_val("srun.busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
